// File: rtl/bcd_stopwatch_pkg.sv
// Shared constants and helpers for the BCD up/down stopwatch.
// Holds digit width, the tick divider calculation and nibble clamping.
package bcd_stopwatch_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    function automatic int calc_div(input int clk_freq, input int tick_hz);
        return clk_freq / tick_hz;
    endfunction

    function automatic logic [BCD_W-1:0] clamp_bcd(input logic [BCD_W-1:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage

// File: rtl/bcd_digit_updown.sv
// One BCD digit of the ripple up/down chain.
// carry means "this digit rolled over" (9->0 up, 0->9 down) while enabled.
module bcd_digit_updown
    import bcd_stopwatch_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    input  logic             en,
    input  logic             dir,
    output logic [BCD_W-1:0] next_digit,
    output logic             carry
);

    always_comb begin
        next_digit = digit;
        carry      = 1'b0;
        if (en) begin
            if (!dir) begin
                if (digit >= BCD_MAX) begin
                    next_digit = '0;
                    carry      = 1'b1;
                end else begin
                    next_digit = digit + 4'd1;
                end
            end else begin
                if (digit == '0) begin
                    next_digit = BCD_MAX;
                    carry      = 1'b1;
                end else begin
                    next_digit = digit - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_updown_stopwatch.sv
// Multi-digit BCD stopwatch: prescaler, up/down ripple count, preset load,
// wrap/saturate boundary policy and lap display freeze.
module bcd_updown_stopwatch
    import bcd_stopwatch_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int TICK_HZ    = 1,
    parameter int NUM_DIGITS = 4,
    parameter int WRAP       = 1
)
(
    input  logic                        clk,
    input  logic                        init_regs,
    input  logic                        count_enabled,
    input  logic                        count_down,
    input  logic                        load,
    input  logic [BCD_W*NUM_DIGITS-1:0] load_value,
    input  logic                        lap,
    output logic [BCD_W*NUM_DIGITS-1:0] time_reading,
    output logic [BCD_W*NUM_DIGITS-1:0] display_reading,
    output logic                        lap_frozen,
    output logic                        tick,
    output logic                        at_zero,
    output logic                        boundary
);

    localparam int DIV = calc_div(CLK_FREQ, TICK_HZ);
    localparam int PW  = $clog2(DIV);
    localparam int W   = BCD_W * NUM_DIGITS;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam bit SAT = (WRAP == 0);

    logic [PW-1:0]       presc_q;
    logic [W-1:0]        time_q;
    logic [W-1:0]        lap_q;
    logic [W-1:0]        time_nx;
    logic [W-1:0]        time_upd;
    logic [W-1:0]        load_clamped;
    logic [NUM_DIGITS:0] chain;
    logic                frozen_q;
    logic                tick_q;
    logic                bnd_q;
    logic                tick_i;
    logic                wrap_evt;

    assign chain[0] = 1'b1;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit_updown u_digit (
            .digit      (time_q[g*BCD_W +: BCD_W]),
            .en         (chain[g]),
            .dir        (count_down),
            .next_digit (time_nx[g*BCD_W +: BCD_W]),
            .carry      (chain[g+1])
        );
        assign load_clamped[g*BCD_W +: BCD_W] =
            clamp_bcd(load_value[g*BCD_W +: BCD_W]);
    end

    // Carry out of the top digit is exactly the all-9s-up / all-0s-down case.
    assign wrap_evt = chain[NUM_DIGITS];
    assign tick_i   = count_enabled && (presc_q == PRESC_MAX);

    always_comb begin
        time_upd = time_nx;
        if (SAT && wrap_evt) begin
            time_upd = time_q;
        end
    end

    always_ff @(posedge clk) begin
        if (init_regs) begin
            presc_q  <= '0;
            time_q   <= '0;
            lap_q    <= '0;
            frozen_q <= 1'b0;
            tick_q   <= 1'b0;
            bnd_q    <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            bnd_q  <= 1'b0;
            if (load) begin
                time_q  <= load_clamped;
                presc_q <= '0;
            end else if (tick_i) begin
                presc_q <= '0;
                time_q  <= time_upd;
                tick_q  <= 1'b1;
                bnd_q   <= wrap_evt;
            end else if (count_enabled) begin
                presc_q <= presc_q + 1'b1;
            end
            // Lap snapshots the value before any same-cycle update.
            if (lap) begin
                if (!frozen_q) begin
                    lap_q    <= time_q;
                    frozen_q <= 1'b1;
                end else begin
                    frozen_q <= 1'b0;
                end
            end
        end
    end

    assign time_reading    = time_q;
    assign display_reading = frozen_q ? lap_q : time_q;
    assign lap_frozen      = frozen_q;
    assign tick            = tick_q;
    assign boundary        = bnd_q;
    assign at_zero         = (time_q == '0);

endmodule

// File: tb/tb_bcd_updown_stopwatch.sv
// Bench for bcd_updown_stopwatch: directed sequences, a load/tick vector
// table, and randomized traffic against a decimal-arithmetic model.
module tb_bcd_updown_stopwatch;

    localparam int ND  = 2;
    localparam int W   = 4 * ND;
    localparam int DIV = 10;
    localparam int TOP = 99;

    logic         clk = 1'b0;
    logic         init_regs = 1'b1;
    logic         count_enabled = 1'b0;
    logic         count_down = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic         lap = 1'b0;

    logic [W-1:0] tw, ts, dw, ds;
    logic         fw, fs, tkw, tks, zw, zs, bw, bs;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bcd_updown_stopwatch #(
        .CLK_FREQ(10), .TICK_HZ(1), .NUM_DIGITS(ND), .WRAP(1)
    ) dut_w (
        .clk(clk), .init_regs(init_regs), .count_enabled(count_enabled),
        .count_down(count_down), .load(load), .load_value(load_value),
        .lap(lap), .time_reading(tw), .display_reading(dw),
        .lap_frozen(fw), .tick(tkw), .at_zero(zw), .boundary(bw)
    );

    bcd_updown_stopwatch #(
        .CLK_FREQ(10), .TICK_HZ(1), .NUM_DIGITS(ND), .WRAP(0)
    ) dut_s (
        .clk(clk), .init_regs(init_regs), .count_enabled(count_enabled),
        .count_down(count_down), .load(load), .load_value(load_value),
        .lap(lap), .time_reading(ts), .display_reading(ds),
        .lap_frozen(fs), .tick(tks), .at_zero(zs), .boundary(bs)
    );

    // Reference model: count held as a plain decimal integer.
    int mv_w = 0, mv_s = 0, mlap_w = 0, mlap_s = 0, mp = 0;
    bit mfz = 0, mt = 0, mbw = 0, mbs = 0;

    function automatic int bcd2int(input logic [W-1:0] b);
        int v = 0;
        int p = 1;
        for (int k = 0; k < ND; k++) begin
            int n = int'(b[4*k +: 4]);
            if (n > 9) n = 9;
            v += n * p;
            p *= 10;
        end
        return v;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r = '0;
        int x = v;
        for (int k = 0; k < ND; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int step_val(input int v, input bit dn, input bit wrap,
                                    output bit b);
        b = 0;
        if (!dn) begin
            if (v == TOP) begin
                b = 1;
                return wrap ? 0 : TOP;
            end
            return v + 1;
        end
        if (v == 0) begin
            b = 1;
            return wrap ? TOP : 0;
        end
        return v - 1;
    endfunction

    always @(posedge clk) begin
        if (init_regs) begin
            mv_w = 0; mv_s = 0; mlap_w = 0; mlap_s = 0; mp = 0;
            mfz = 0; mt = 0; mbw = 0; mbs = 0;
        end else begin
            mt = 0; mbw = 0; mbs = 0;
            if (lap) begin
                if (!mfz) begin
                    mlap_w = mv_w;
                    mlap_s = mv_s;
                    mfz = 1;
                end else begin
                    mfz = 0;
                end
            end
            if (load) begin
                mv_w = bcd2int(load_value);
                mv_s = mv_w;
                mp = 0;
            end else if (count_enabled) begin
                if (mp == DIV - 1) begin
                    mp = 0;
                    mt = 1;
                    mv_w = step_val(mv_w, count_down, 1'b1, mbw);
                    mv_s = step_val(mv_s, count_down, 1'b0, mbs);
                end else begin
                    mp++;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        init_regs = 1'b1;
        load = 1'b0;
        lap = 1'b0;
        step();
        init_regs = 1'b0;
    endtask

    task automatic wait_tick(output bit got);
        got = 0;
        for (int i = 0; i < 2 * DIV; i++) begin
            step();
            if (tkw) begin
                got = 1;
                break;
            end
        end
    endtask

    task automatic check_model();
        chk("rnd_time_w", 32'(tw), 32'(int2bcd(mv_w)));
        chk("rnd_time_s", 32'(ts), 32'(int2bcd(mv_s)));
        chk("rnd_disp_w", 32'(dw), 32'(int2bcd(mfz ? mlap_w : mv_w)));
        chk("rnd_disp_s", 32'(ds), 32'(int2bcd(mfz ? mlap_s : mv_s)));
        chk("rnd_frozen", 32'({fw, fs}), 32'({mfz, mfz}));
        chk("rnd_tick", 32'({tkw, tks}), 32'({mt, mt}));
        chk("rnd_bnd_w", 32'(bw), 32'(mbw));
        chk("rnd_bnd_s", 32'(bs), 32'(mbs));
        chk("rnd_zero", 32'({zw, zs}), 32'({mv_w == 0, mv_s == 0}));
    endtask

    typedef struct {
        logic [W-1:0] lv;
        bit           dn;
        int           nt;
        logic [W-1:0] ew;
        logic [W-1:0] es;
        logic [3:0]   mw;
        logic [3:0]   ms;
    } vec_t;

    vec_t vt[9];

    initial begin
        int nticks;
        int last;
        bit got;
        logic [3:0] bmw, bms;

        vt[0] = '{8'h99, 1'b0, 1, 8'h00, 8'h99, 4'b0001, 4'b0001};
        vt[1] = '{8'h00, 1'b1, 1, 8'h99, 8'h00, 4'b0001, 4'b0001};
        vt[2] = '{8'h01, 1'b1, 3, 8'h98, 8'h00, 4'b0010, 4'b0110};
        vt[3] = '{8'h09, 1'b0, 1, 8'h10, 8'h10, 4'b0000, 4'b0000};
        vt[4] = '{8'h10, 1'b1, 1, 8'h09, 8'h09, 4'b0000, 4'b0000};
        vt[5] = '{8'hA7, 1'b0, 0, 8'h97, 8'h97, 4'b0000, 4'b0000};
        vt[6] = '{8'h5F, 1'b0, 0, 8'h59, 8'h59, 4'b0000, 4'b0000};
        vt[7] = '{8'h98, 1'b0, 2, 8'h00, 8'h99, 4'b0010, 4'b0010};
        vt[8] = '{8'h90, 1'b1, 1, 8'h89, 8'h89, 4'b0000, 4'b0000};

        // Reset state
        step();
        init_regs = 1'b0;
        chk("reset_time", 32'({tw, ts}), 32'h0);
        chk("reset_flags", 32'({fw, tkw, bw, zw}), 32'b0001);

        // Free run 100 cycles
        count_enabled = 1'b1;
        nticks = 0;
        last = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (tkw) begin
                nticks++;
                chk("tick_spacing", 32'(i - last), 32'(DIV));
                last = i;
            end
            if (bw) chk("run_boundary", 32'(bw), 32'h0);
        end
        chk("run_ticks", 32'(nticks), 32'd10);
        chk("run_time", 32'(tw), 32'h10);

        // Pause keeps the prescaler
        do_reset();
        for (int i = 0; i < 25; i++) step();
        chk("pre_pause", 32'(tw), 32'h02);
        count_enabled = 1'b0;
        nticks = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (tkw) nticks++;
        end
        chk("pause_ticks", 32'(nticks), 32'd0);
        count_enabled = 1'b1;
        last = 0;
        for (int i = 1; i <= 2 * DIV; i++) begin
            step();
            if (tkw) begin
                last = i;
                break;
            end
        end
        chk("resume_delay", 32'(last), 32'd5);
        chk("resume_time", 32'(tw), 32'h03);

        // Load clamp beats coincident tick; prescaler cleared
        do_reset();
        for (int i = 0; i < DIV - 1; i++) step();
        load = 1'b1;
        load_value = 8'hA7;
        step();
        load = 1'b0;
        chk("ld_clamp", 32'(tw), 32'h97);
        chk("ld_tick", 32'({tkw, bw}), 32'h0);
        last = 0;
        for (int i = 1; i <= 2 * DIV; i++) begin
            step();
            if (tkw) begin
                last = i;
                break;
            end
        end
        chk("ld_presc", 32'(last), 32'(DIV));
        chk("ld_after", 32'(tw), 32'h98);

        // Load / tick vector table
        for (int v = 0; v < 9; v++) begin
            count_down = vt[v].dn;
            load_value = vt[v].lv;
            load = 1'b1;
            step();
            load = 1'b0;
            bmw = '0;
            bms = '0;
            for (int t = 0; t < vt[v].nt; t++) begin
                wait_tick(got);
                if (!got) chk("tbl_timeout", 32'(v), 32'hFFFF);
                bmw[t] = bw;
                bms[t] = bs;
            end
            chk($sformatf("tbl%0d_w", v), 32'(tw), 32'(vt[v].ew));
            chk($sformatf("tbl%0d_s", v), 32'(ts), 32'(vt[v].es));
            chk($sformatf("tbl%0d_z", v), 32'({zw, zs}),
                32'({vt[v].ew == 0, vt[v].es == 0}));
            if (vt[v].nt > 0) begin
                chk($sformatf("tbl%0d_bw", v), 32'(bmw), 32'(vt[v].mw));
                chk($sformatf("tbl%0d_bs", v), 32'(bms), 32'(vt[v].ms));
            end
        end
        count_down = 1'b0;

        // Lap capture on a tick cycle
        do_reset();
        for (int i = 0; i < 6 * DIV - 1; i++) step();
        chk("lap_pre", 32'(tw), 32'h05);
        lap = 1'b1;
        step();
        lap = 1'b0;
        chk("lap_cap", 32'({dw, fw}), 32'({8'h05, 1'b1}));
        chk("lap_live", 32'(tw), 32'h06);
        for (int i = 0; i < 2 * DIV; i++) step();
        chk("lap_hold", 32'({tw, dw}), 32'({8'h08, 8'h05}));
        lap = 1'b1;
        step();
        lap = 1'b0;
        chk("lap_rel", 32'({dw, fw}), 32'({8'h08, 1'b0}));
        lap = 1'b1;
        step();
        lap = 1'b0;
        for (int i = 0; i < 5; i++) step();
        init_regs = 1'b1;
        lap = 1'b1;
        load = 1'b1;
        load_value = 8'h55;
        step();
        init_regs = 1'b0;
        lap = 1'b0;
        load = 1'b0;
        chk("mid_reset", 32'({tw, dw}), 32'h0);
        chk("mid_reset_fl", 32'({fw, tkw, bw, zw}), 32'b0001);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int r;
            count_enabled = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 39) == 0) count_down = ~count_down;
            load = ($urandom_range(0, 29) == 0);
            r = $urandom_range(0, 4);
            case (r)
                0: load_value = 8'h99;
                1: load_value = 8'h00;
                2: load_value = 8'h01;
                3: load_value = 8'h98;
                default: load_value = 8'($urandom);
            endcase
            lap = ($urandom_range(0, 29) == 0);
            init_regs = ($urandom_range(0, 199) == 0);
            step();
            check_model();
        end
        init_regs = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
